ir_tx_scheduler: RTL and testbench

IR_TX_SCHEDULER -- requirements
Module: ir_tx_scheduler

---
 rtl/ir_pkg.sv | 29 ++
 rtl/ir_rr_arbiter.sv | 32 +++
 rtl/ir_tx_scheduler.sv | 172 +++++++++++++++++
 tb/tb_ir_tx_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the IR transmit scheduler and the matching ir_decoder:
// state encoding, code width and default phase timings in clock cycles.
package ir_pkg;

  localparam int CODE_W = 32;

  localparam int SBD_DEF  = 900;
  localparam int SSD_DEF  = 450;
  localparam int BBD_DEF  = 60;
  localparam int BSD0_DEF = 60;
  localparam int BSD1_DEF = 160;
  localparam int GAP_DEF  = 500;

  // Encoding is fixed so that state_out reads the same with or without the gap feature
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SYNC_BURST   = 3'd1,
    ST_SYNC_SILENCE = 3'd2,
    ST_BIT_BURST    = 3'd3,
    ST_BIT_SILENCE  = 3'd4,
    ST_STOP_BURST   = 3'd5,
    ST_GAP          = 3'd6
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_rr_arbiter.sv
// Two-requester round-robin arbiter: combinational winner, registered priority
// pointer that moves to the other requester after every grant.
module ir_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] win
);

  logic ptr;

  // A lone request always wins; on a tie the pointer names the favoured requester
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take && (req != 2'b00)) begin
      ptr <= win[0];
    end
  end

endmodule

// File: rtl/ir_tx_scheduler.sv
// IR packet transmitter shared by two requesters: sync burst/silence, 32 pulse-distance
// coded bits MSB first, stop burst. Define IR_TX_GAP_EN to add a post-packet GAP state.
module ir_tx_scheduler
  import ir_pkg::*;
#(
  parameter int SBD  = SBD_DEF,
  parameter int SSD  = SSD_DEF,
  parameter int BBD  = BBD_DEF,
  parameter int BSD0 = BSD0_DEF,
  parameter int BSD1 = BSD1_DEF,
  parameter int GAP  = GAP_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        req_in,
  input  logic [CODE_W-1:0] code0_in,
  input  logic [CODE_W-1:0] code1_in,
  output logic [1:0]        grant_out,
  output logic              signal_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [2:0]        state_out
);

  localparam int MAXD = max2(max2(max2(SBD, SSD), max2(BBD, BSD0)), max2(BSD1, GAP));
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [CW-1:0] SBD_LD  = CW'(SBD - 1);
  localparam logic [CW-1:0] SSD_LD  = CW'(SSD - 1);
  localparam logic [CW-1:0] BBD_LD  = CW'(BBD - 1);
  localparam logic [CW-1:0] BSD0_LD = CW'(BSD0 - 1);
  localparam logic [CW-1:0] BSD1_LD = CW'(BSD1 - 1);
  localparam logic          STOP_ONE_CYCLE = (BBD == 1);
`ifdef IR_TX_GAP_EN
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CODE_W-1:0] shreg;
  logic [4:0]        bit_idx;
  logic [1:0]        win;
  logic              take;

  assign take      = (state == ST_IDLE) && (req_in != 2'b00);
  assign state_out = state;

  ir_rr_arbiter u_arb (
    .clk  (clk_in),
    .rst  (rst_in),
    .req  (req_in),
    .take (take),
    .win  (win)
  );

  // Each phase loads duration-1 on entry and advances when the counter reaches zero,
  // so phases abut with no idle cycles; all outputs are registered with the state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      grant_out  <= 2'b00;
      signal_out <= 1'b1;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      grant_out <= 2'b00;
      done_out  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            shreg      <= win[1] ? code1_in : code0_in;
            grant_out  <= win;
            state      <= ST_SYNC_BURST;
            cnt        <= SBD_LD;
            bit_idx    <= 5'd31;
            signal_out <= 1'b0;
            busy_out   <= 1'b1;
          end
        end

        ST_SYNC_BURST: begin
          if (cnt == '0) begin
            state      <= ST_SYNC_SILENCE;
            cnt        <= SSD_LD;
            signal_out <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SYNC_SILENCE: begin
          if (cnt == '0) begin
            state      <= ST_BIT_BURST;
            cnt        <= BBD_LD;
            signal_out <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_BIT_BURST: begin
          if (cnt == '0) begin
            state      <= ST_BIT_SILENCE;
            cnt        <= shreg[CODE_W-1] ? BSD1_LD : BSD0_LD;
            signal_out <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_BIT_SILENCE: begin
          if (cnt == '0) begin
            cnt        <= BBD_LD;
            signal_out <= 1'b0;
            if (bit_idx == 5'd0) begin
              state    <= ST_STOP_BURST;
              done_out <= STOP_ONE_CYCLE;
            end else begin
              state   <= ST_BIT_BURST;
              shreg   <= {shreg[CODE_W-2:0], 1'b0};
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // done_out is raised one edge early so it lines up with the final stop cycle
        ST_STOP_BURST: begin
          if (cnt == '0) begin
            signal_out <= 1'b1;
`ifdef IR_TX_GAP_EN
            state      <= ST_GAP;
            cnt        <= GAP_LD;
`else
            state      <= ST_IDLE;
            busy_out   <= 1'b0;
`endif
          end else begin
            cnt      <= cnt - 1'b1;
            done_out <= (cnt == CW'(1));
          end
        end

        ST_GAP: begin
`ifdef IR_TX_GAP_EN
          if (cnt == '0) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
`else
          state    <= ST_IDLE;
          busy_out <= 1'b0;
`endif
          signal_out <= 1'b1;
        end

        default: begin
          state      <= ST_IDLE;
          busy_out   <= 1'b0;
          signal_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Self-checking bench for ir_tx_scheduler: table vectors, hand-written corner sequences
// and random packets checked against a segment-level model of the IR waveform.
module tb_ir_tx_scheduler;
  import ir_pkg::*;

  localparam int SBD  = 900;
  localparam int SSD  = 450;
  localparam int BBD  = 60;
  localparam int BSD0 = 60;
  localparam int BSD1 = 160;
  localparam int GAP  = 500;
`ifdef IR_TX_GAP_EN
  localparam int B2B_WAIT = GAP + 1;
`else
  localparam int B2B_WAIT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] code0 = '0;
  logic [31:0] code1 = '0;
  logic [1:0]  grant;
  logic        signal;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int exp_segs[$];
  int got_segs[$];
  bit model_ptr;

  logic [1:0] res_grant;
  int         res_wait;
  int         res_len;
  bit         res_done_ok;
  bit         res_busy_ok;
  bit         res_low_ok;
  bit         res_timeout;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [1:0]  exp_grant;
    int          exp_len;
  } vec_t;
  vec_t vecs[3];

  ir_tx_scheduler #(
    .SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1), .GAP(GAP)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .req_in     (req),
    .code0_in   (code0),
    .code1_in   (code1),
    .grant_out  (grant),
    .signal_out (signal),
    .busy_out   (busy),
    .done_out   (done),
    .state_out  (state)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference waveform as alternating low/high run lengths starting with the sync burst
  task automatic build_model(input logic [31:0] c);
    exp_segs.delete();
    exp_segs.push_back(SBD);
    exp_segs.push_back(SSD);
    for (int i = 31; i >= 0; i--) begin
      exp_segs.push_back(BBD);
      exp_segs.push_back(c[i] ? BSD1 : BSD0);
    end
    exp_segs.push_back(BBD);
  endtask

  task automatic model_arbitrate(input logic [1:0] r, output logic [1:0] g);
    int w;
    w = -1;
    if (r == 2'b01) w = 0;
    else if (r == 2'b10) w = 1;
    else if (r == 2'b11) w = model_ptr ? 1 : 0;
    g = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    if (w >= 0) model_ptr = (w == 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(negedge clk);
    check_output("reset state", state, 0);
    check_output("reset signal", signal, 1);
    check_output("reset grant", grant, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    rst = 1'b0;
    model_ptr = 1'b0;
  endtask

  task automatic wait_grant(output logic [1:0] g, output int n);
    g = 2'b00;
    n = 0;
    while (g == 2'b00 && n < 1000) begin
      @(negedge clk);
      n++;
      g = grant;
    end
  endtask

  // Drives one request, captures the packet as run lengths up to done_out, then one more cycle
  task automatic apply_stimulus(input logic [1:0] r, input logic [31:0] c0, input logic [31:0] c1);
    bit level, finished;
    int run, dones;
    req = r;
    code0 = c0;
    code1 = c1;
    res_timeout = 1'b0;
    res_len = 0;
    got_segs.delete();
    wait_grant(res_grant, res_wait);
    if (res_grant == 2'b00) begin
      res_timeout = 1'b1;
      req = 2'b00;
      return;
    end
    req = r & ~res_grant;
    res_low_ok  = (signal == 1'b0);
    res_busy_ok = busy;
    level = signal;
    run = 1;
    res_len = 1;
    dones = done ? 1 : 0;
    finished = done;
    while (!finished && res_len < 20000) begin
      @(negedge clk);
      res_len++;
      if (!busy) res_busy_ok = 1'b0;
      if (done) begin
        dones++;
        finished = 1'b1;
      end
      if (signal == level) run++;
      else begin
        got_segs.push_back(run);
        level = signal;
        run = 1;
      end
    end
    got_segs.push_back(run);
    if (!finished) res_timeout = 1'b1;
    @(negedge clk);
    res_done_ok = (dones == 1) && !done && signal && (grant == 2'b00);
  endtask

  task automatic check_packet(input string tag, input logic [1:0] exp_g, input logic [31:0] exp_code,
                              input int exp_len);
    int model_len, bad;
    logic [31:0] decoded;
    check_output({tag, " timeout"}, res_timeout, 0);
    check_output({tag, " grant"}, res_grant, exp_g);
    build_model(exp_code);
    model_len = 0;
    foreach (exp_segs[i]) model_len += exp_segs[i];
    check_output({tag, " length"}, res_len, model_len);
    if (exp_len > 0) check_output({tag, " fixed length"}, res_len, exp_len);
    bad = (got_segs.size() == exp_segs.size()) ? -1 : 999;
    if (bad < 0)
      foreach (exp_segs[i]) if (bad < 0 && got_segs[i] != exp_segs[i]) bad = i;
    check_output({tag, " first bad segment"}, bad, -1);
    decoded = '0;
    for (int i = 0; i < 32; i++)
      if (3 + 2 * i < got_segs.size()) decoded[31 - i] = (got_segs[3 + 2 * i] == BSD1);
    check_output({tag, " decoded code"}, decoded, exp_code);
    check_output({tag, " done pulse"}, res_done_ok, 1);
    check_output({tag, " busy"}, res_busy_ok, 1);
    check_output({tag, " line low at grant"}, res_low_ok, 1);
  endtask

  initial begin
    logic [1:0]  g, eg;
    logic [31:0] rc0, rc1, exp_code;
    int n, bs;
    bit saw_done, stray;
    logic [2:0] prev;

    vecs[0] = '{req: 2'b01, c0: 32'hABCD1234, c1: 32'h0000_0000, exp_grant: 2'b01, exp_len: 6750};
    vecs[1] = '{req: 2'b10, c0: 32'h5A5A_5A5A, c1: 32'h0000_0000, exp_grant: 2'b10, exp_len: 5250};
    vecs[2] = '{req: 2'b11, c0: 32'hFFFF_FFFF, c1: 32'h1234_5678, exp_grant: 2'b01, exp_len: 8450};

    apply_reset();

    for (int v = 0; v < 3; v++) begin
      model_arbitrate(vecs[v].req, eg);
      apply_stimulus(vecs[v].req, vecs[v].c0, vecs[v].c1);
      exp_code = vecs[v].exp_grant[1] ? vecs[v].c1 : vecs[v].c0;
      check_packet($sformatf("vec%0d", v), vecs[v].exp_grant, exp_code, vecs[v].exp_len);
    end
    req = 2'b00;

    // Both requesters from reset: requester 0 first, requester 1 back to back
    apply_reset();
    apply_stimulus(2'b11, 32'h19861989, 32'h12345678);
    check_packet("pair first", 2'b01, 32'h19861989, 0);
    apply_stimulus(2'b10, 32'h19861989, 32'h12345678);
    check_packet("pair second", 2'b10, 32'h12345678, 0);
    check_output("pair grant latency", res_wait, B2B_WAIT);
    req = 2'b00;
    model_ptr = 1'b0;

    // A request raised and dropped while busy must never be granted
    req = 2'b01;
    code0 = 32'h0;
    wait_grant(g, n);
    check_output("drop test grant", g, 2'b01);
    req = 2'b00;
    repeat (100) @(negedge clk);
    req = 2'b10;
    repeat (30) @(negedge clk);
    req = 2'b00;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_output("drop test done seen", done, 1);
    stray = 1'b0;
    repeat (B2B_WAIT + 10) begin
      @(negedge clk);
      if (grant != 2'b00) stray = 1'b1;
    end
    check_output("dropped request grant", stray, 0);
    check_output("idle after drop", state, 0);

    // Reset in the silence of bit 20 (12th bit sent) aborts without done_out
    apply_reset();
    req = 2'b01;
    code0 = $urandom;
    wait_grant(g, n);
    check_output("abort grant", g, 2'b01);
    req = 2'b00;
    bs = 0;
    prev = state;
    saw_done = 1'b0;
    n = 0;
    while (bs < 12 && n < 20000) begin
      @(negedge clk);
      n++;
      if (done) saw_done = 1'b1;
      if (state == 3'd4 && prev != 3'd4) bs++;
      prev = state;
    end
    check_output("reached bit 20 silence", bs, 12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("abort state", state, 0);
    check_output("abort signal", signal, 1);
    check_output("abort busy", busy, 0);
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_output("abort done never", saw_done, 0);
    req = 2'b11;
    wait_grant(g, n);
    check_output("grant after abort", g, 2'b01);
    req = 2'b00;
    apply_reset();

    for (int k = 0; k < 3; k++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      rc0 = $urandom;
      rc1 = $urandom;
      model_arbitrate(r, eg);
      apply_stimulus(r, rc0, rc1);
      check_packet($sformatf("rand%0d", k), eg, eg[1] ? rc1 : rc0, 0);
    end
    req = 2'b00;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
